// File: rtl/multicycle_control_unit_if.sv
// Decoder-to-datapath bundle: instruction fields and ALU flags in, mux selects and enables out.
// master = control unit, slave = datapath side.
interface multicycle_control_unit_if #(
  parameter int ALUCTRL_W = 3
);
  logic [1:0]           Op;
  logic [5:0]           Funct;
  logic [3:0]           Rd;
  logic [3:0]           Cond;
  logic [3:0]           ALUFlags;
  logic                 PCWrite;
  logic                 AdrSrc;
  logic                 MemW;
  logic                 IRWrite;
  logic [1:0]           ResultSrc;
  logic                 ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic                 RegW;
  logic [1:0]           ImmSrc;
  logic [1:0]           RegSrc;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic [3:0]           Flags;
  logic                 Illegal;

  modport master (
    input  Op, Funct, Rd, Cond, ALUFlags,
    output PCWrite, AdrSrc, MemW, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegW, ImmSrc, RegSrc, ALUControl, Flags, Illegal
  );

  modport slave (
    output Op, Funct, Rd, Cond, ALUFlags,
    input  PCWrite, AdrSrc, MemW, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegW, ImmSrc, RegSrc, ALUControl, Flags, Illegal
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore FSM control unit for the multi-cycle ARM-subset core, with MUL stall and NZCV register.
// Define COND_EXEC_EN to gate each instruction on its condition field in DECODE.
module multicycle_control_unit #(
  parameter int MUL_CYCLES = 4,
  parameter int ALUCTRL_W  = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  multicycle_control_unit_if.master   bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_ORR = 3'b101;

  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] mul_cnt;
  logic [3:0] mul_cnt_nxt;
  logic [3:0] flags_q;
  logic [3:0] flags_nxt;

  logic [2:0] alu_op;
  logic       in_exec;
  logic       exec_last;
  logic       cond_pass;

  logic       pc_write;
  logic       adr_src;
  logic       mem_w;
  logic       ir_write;
  logic [1:0] result_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       reg_w;
  logic [2:0] alu_ctl;
  logic       illegal;

  always_comb begin
    alu_op = ALU_ADD;
    case (bus.Funct[4:1])
      4'b0000: alu_op = ALU_ADD;
      4'b0001: alu_op = ALU_SUB;
      4'b0010: alu_op = ALU_MUL;
      4'b1000: alu_op = ALU_AND;
      4'b1001: alu_op = ALU_ORR;
      default: alu_op = ALU_ADD;
    endcase
  end

  // MUL holds EXEC for MUL_CYCLES cycles; every other op leaves after one.
  assign in_exec   = (state == EXECR) || (state == EXECI);
  assign exec_last = in_exec && ((alu_op != ALU_MUL) || (mul_cnt == MUL_LAST));

  always_comb begin
    mul_cnt_nxt = 4'd0;
    if (in_exec && (alu_op == ALU_MUL) && !exec_last) begin
      mul_cnt_nxt = mul_cnt + 4'd1;
    end
  end

`ifdef COND_EXEC_EN
  logic flag_n;
  logic flag_z;
  logic flag_c;
  logic flag_v;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  always_comb begin
    cond_pass = 1'b1;
    case (bus.Cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = !flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = !flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = !flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = !flag_v;
      4'b1000: cond_pass = flag_c && !flag_z;
      4'b1001: cond_pass = !flag_c || flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
      4'b1101: cond_pass = flag_z || (flag_n != flag_v);
      default: cond_pass = 1'b1;
    endcase
  end
`else
  logic unused_cond;

  assign unused_cond = ^bus.Cond;
  assign cond_pass   = 1'b1;
`endif

  // Flag writes only on the cycle the result is final; C/V only meaningful for ADD/SUB.
  always_comb begin
    flags_nxt = flags_q;
    if (exec_last && bus.Funct[0]) begin
      flags_nxt[3:2] = bus.ALUFlags[3:2];
      if ((alu_op == ALU_ADD) || (alu_op == ALU_SUB)) begin
        flags_nxt[1:0] = bus.ALUFlags[1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      mul_cnt <= 4'd0;
      flags_q <= 4'b0000;
    end else begin
      state   <= state_nxt;
      mul_cnt <= mul_cnt_nxt;
      flags_q <= flags_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_w      = 1'b0;
    ir_write   = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    reg_w      = 1'b0;
    alu_ctl    = ALU_ADD;
    illegal    = 1'b0;
    case (state)
      FETCH: begin
        adr_src    = 1'b0;
        ir_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = 1'b1;
        state_nxt  = DECODE;
      end
      DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (!cond_pass) begin
          state_nxt = FETCH;
        end else begin
          case (bus.Op)
            2'b00:   state_nxt = bus.Funct[5] ? EXECI : EXECR;
            2'b01:   state_nxt = MEMADR;
            2'b10:   state_nxt = BRANCH;
            default: begin
              state_nxt = FETCH;
              illegal   = 1'b1;
            end
          endcase
        end
      end
      MEMADR: begin
        alu_src_a = 1'b0;
        alu_src_b = 2'b01;
        state_nxt = bus.Funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src    = 1'b1;
        result_src = 2'b00;
        state_nxt  = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        pc_write   = (bus.Rd == 4'b1111);
        state_nxt  = FETCH;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_w     = 1'b1;
        state_nxt = FETCH;
      end
      EXECR, EXECI: begin
        alu_src_a = 1'b0;
        alu_src_b = (state == EXECI) ? 2'b01 : 2'b00;
        alu_ctl   = alu_op;
        state_nxt = exec_last ? ALUWB : state;
      end
      ALUWB: begin
        result_src = 2'b00;
        reg_w      = 1'b1;
        pc_write   = (bus.Rd == 4'b1111);
        state_nxt  = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
        state_nxt  = FETCH;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  // Architectural strobes are held off for the whole time reset is low.
  assign bus.PCWrite    = pc_write & rst_n;
  assign bus.IRWrite    = ir_write & rst_n;
  assign bus.RegW       = reg_w & rst_n;
  assign bus.MemW       = mem_w & rst_n;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = ALUCTRL_W'(alu_ctl);
  assign bus.Illegal    = illegal;
  assign bus.Flags      = flags_q;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {(bus.Op == 2'b01), (bus.Op == 2'b10)};

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed plus random instruction streams checked cycle by cycle against an instruction-level model.
module tb_multicycle_control_unit;

  localparam int MUL_CYCLES = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  multicycle_control_unit_if #(.ALUCTRL_W(3)) bus ();

  multicycle_control_unit #(
    .MUL_CYCLES (MUL_CYCLES),
    .ALUCTRL_W  (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] res;
    logic       srca;
    logic [1:0] srcb;
    logic       regw;
    logic [1:0] imm;
    logic [1:0] regsrc;
    logic [2:0] alu;
    logic       ill;
  } ctl_t;

  typedef enum {K_F, K_D, K_MA, K_MR, K_MWB, K_MW, K_X, K_AWB, K_B} kind_t;

  int         total  = 0;
  int         passed = 0;
  int         fails  = 0;
  logic [3:0] mflags;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] alu_of(input logic [3:0] cmd);
    case (cmd)
      4'd0:    return 3'b000;
      4'd1:    return 3'b001;
      4'd2:    return 3'b010;
      4'd8:    return 3'b100;
      4'd9:    return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
`ifdef COND_EXEC_EN
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return cy;
      4'd3:    return !cy;
      4'd4:    return n;
      4'd5:    return !n;
      4'd6:    return v;
      4'd7:    return !v;
      4'd8:    return cy && !z;
      4'd9:    return !cy || z;
      4'd10:   return n == v;
      4'd11:   return n != v;
      4'd12:   return !z && (n == v);
      4'd13:   return z || (n != v);
      default: return 1'b1;
    endcase
`else
    return (c == c) || (f == f);
`endif
  endfunction

  function automatic ctl_t observe();
    ctl_t o;
    o = '{bus.PCWrite, bus.AdrSrc, bus.MemW, bus.IRWrite, bus.ResultSrc, bus.ALUSrcA,
          bus.ALUSrcB, bus.RegW, bus.ImmSrc, bus.RegSrc, bus.ALUControl, bus.Illegal};
    return o;
  endfunction

  // Expected value plus care mask for one cycle; enables are always checked.
  task automatic exp_of(input kind_t k, input logic [1:0] op, input logic [5:0] funct,
                        input logic [3:0] rd, input logic ill, output ctl_t e, output ctl_t c);
    e = '0;
    c = '0;
    c.pcw = 1'b1; c.irw = 1'b1; c.memw = 1'b1; c.regw = 1'b1; c.ill = 1'b1;
    c.imm = 2'b11; c.regsrc = 2'b11;
    e.imm = op;
    e.regsrc = {op == 2'b01, op == 2'b10};
    case (k)
      K_F: begin
        e.irw = 1'b1; e.pcw = 1'b1; e.adr = 1'b0; e.srca = 1'b1; e.srcb = 2'b10;
        e.alu = 3'b000; e.res = 2'b10;
        c.adr = 1'b1; c.srca = 1'b1; c.srcb = 2'b11; c.alu = 3'b111; c.res = 2'b11;
      end
      K_D: begin
        e.srca = 1'b1; e.srcb = 2'b10; e.res = 2'b10; e.alu = 3'b000; e.ill = ill;
        c.srca = 1'b1; c.srcb = 2'b11; c.res = 2'b11; c.alu = 3'b111;
      end
      K_MA: begin
        e.srca = 1'b0; e.srcb = 2'b01; e.alu = 3'b000;
        c.srca = 1'b1; c.srcb = 2'b11; c.alu = 3'b111;
      end
      K_MR: begin
        e.adr = 1'b1; e.res = 2'b00;
        c.adr = 1'b1; c.res = 2'b11;
      end
      K_MWB: begin
        e.res = 2'b01; e.regw = 1'b1; e.pcw = (rd == 4'hF);
        c.res = 2'b11;
      end
      K_MW: begin
        e.adr = 1'b1; e.memw = 1'b1;
        c.adr = 1'b1;
      end
      K_X: begin
        e.srca = 1'b0; e.srcb = funct[5] ? 2'b01 : 2'b00; e.alu = alu_of(funct[4:1]);
        c.srca = 1'b1; c.srcb = 2'b11; c.alu = 3'b111;
      end
      K_AWB: begin
        e.res = 2'b00; e.regw = 1'b1; e.pcw = (rd == 4'hF);
        c.res = 2'b11;
      end
      default: begin
        e.srca = 1'b0; e.srcb = 2'b01; e.alu = 3'b000; e.res = 2'b10; e.pcw = 1'b1;
        c.srca = 1'b1; c.srcb = 2'b11; c.alu = 3'b111; c.res = 2'b11;
      end
    endcase
  endtask

  task automatic check_ctl(input string tag, input ctl_t e, input ctl_t c);
    ctl_t o;
    o = observe();
    check(tag, 32'(o & c), 32'(e & c));
  endtask

  // Starts at a falling edge in FETCH, returns at the falling edge of the next FETCH.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                           input logic [3:0] cond, input logic fix_af, input logic [3:0] af,
                           input logic abort_mw);
    kind_t      ks[$];
    int         nexec;
    int         xi;
    logic       go;
    logic       ill;
    logic [3:0] a;
    logic [2:0] aop;
    ctl_t       e;
    ctl_t       c;

    bus.Op    = op;
    bus.Funct = funct;
    bus.Rd    = rd;
    bus.Cond  = cond;
    aop   = alu_of(funct[4:1]);
    go    = cond_ok(cond, mflags);
    ill   = go && (op == 2'b11);
    nexec = (aop == 3'b010) ? MUL_CYCLES : 1;
    xi    = 0;
    ks    = {K_F, K_D};
    if (go) begin
      case (op)
        2'b00: begin
          repeat (nexec) ks.push_back(K_X);
          ks.push_back(K_AWB);
        end
        2'b01: begin
          ks.push_back(K_MA);
          if (funct[0]) begin
            ks.push_back(K_MR);
            ks.push_back(K_MWB);
          end else begin
            ks.push_back(K_MW);
          end
        end
        2'b10:   ks.push_back(K_B);
        default: ;
      endcase
    end

    foreach (ks[i]) begin
      a = fix_af ? af : 4'($urandom);
      bus.ALUFlags = a;
      #1;
      exp_of(ks[i], op, funct, rd, ill, e, c);
      check_ctl($sformatf("ctl_%s_c%0d", ks[i].name(), i + 1), e, c);
      check("flags", 32'(bus.Flags), 32'(mflags));
      if (ks[i] == K_X) begin
        xi++;
        if ((xi == nexec) && funct[0]) begin
          mflags[3:2] = a[3:2];
          if (aop == 3'b000 || aop == 3'b001) mflags[1:0] = a[1:0];
        end
      end
      if (abort_mw && ks[i] == K_MW) begin
        rst_n = 1'b0;
        #1;
        mflags = 4'b0000;
        exp_of(K_F, op, funct, rd, 1'b0, e, c);
        e.pcw = 1'b0;
        e.irw = 1'b0;
        check_ctl("abort_ctl", e, c);
        check("abort_memw", 32'(bus.MemW), 32'd0);
        check("abort_flags", 32'(bus.Flags), 32'(mflags));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    ctl_t       e;
    ctl_t       c;
    logic [1:0] op;
    logic [3:0] cmd;
    logic [3:0] rd;
    int         r;

    rst_n        = 1'b0;
    bus.Op       = 2'b00;
    bus.Funct    = 6'b0;
    bus.Rd       = 4'h0;
    bus.Cond     = 4'hE;
    bus.ALUFlags = 4'h0;
    mflags       = 4'b0000;

    repeat (2) @(negedge clk);
    #1;
    exp_of(K_F, 2'b00, 6'b0, 4'h0, 1'b0, e, c);
    e.pcw = 1'b0;
    e.irw = 1'b0;
    check_ctl("reset_ctl", e, c);
    check("reset_flags", 32'(bus.Flags), 32'd0);
    rst_n = 1'b1;

    // ANDS from cleared flags: N,Z follow ALU, C,V stay zero.
    run_instr(2'b00, 6'b010001, 4'h2, 4'hE, 1'b1, 4'b1011, 1'b0);
    #1 check("ands_flags", 32'(bus.Flags), 32'b1000);
    // EQ with Z clear: skipped when conditional execution is built in.
    run_instr(2'b00, 6'b001000, 4'h1, 4'h0, 1'b1, 4'b0110, 1'b0);
    run_instr(2'b01, 6'b011000, 4'h3, 4'hE, 1'b0, 4'h0, 1'b1);
    run_instr(2'b00, 6'b101001, 4'h1, 4'hE, 1'b1, 4'b0110, 1'b0);
    #1 check("adds_flags", 32'(bus.Flags), 32'b0110);
    run_instr(2'b00, 6'b000100, 4'h4, 4'hE, 1'b0, 4'h0, 1'b0);
    run_instr(2'b01, 6'b011001, 4'hF, 4'hE, 1'b0, 4'h0, 1'b0);
    run_instr(2'b01, 6'b011000, 4'h5, 4'hE, 1'b0, 4'h0, 1'b0);
    run_instr(2'b10, 6'b000000, 4'h0, 4'hE, 1'b0, 4'h0, 1'b0);
    #1 check("branch_flags", 32'(bus.Flags), 32'b0110);
    run_instr(2'b11, 6'b000000, 4'h0, 4'hE, 1'b0, 4'h0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      r  = $urandom_range(0, 9);
      op = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      case ($urandom_range(0, 5))
        0:       cmd = 4'd0;
        1:       cmd = 4'd1;
        2:       cmd = 4'd2;
        3:       cmd = 4'd8;
        4:       cmd = 4'd9;
        default: cmd = 4'($urandom);
      endcase
      rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      run_instr(op, {1'($urandom), cmd, 1'($urandom)}, rd, 4'($urandom), 1'b0, 4'h0, 1'b0);
    end

    #1 check("final_flags", 32'(bus.Flags), 32'(mflags));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
